// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage requester and the ALU/MDU.
// The requester drives the op and operands; the unit returns results and ready.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, c, hi, lo, ovf, dz
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, c, hi, lo, ovf, dz
    );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered single-cycle results and an iterative
// shift-add multiplier / restoring divider that write HI/LO after WIDTH cycles.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mdu_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_reg;
    logic               ready_reg;
    logic               out_valid_reg;
    logic               ovf_reg;
    logic               dz_reg;
    logic [WIDTH-1:0]   c_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [SH_W-1:0]    cnt_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic [WIDTH-1:0]   dvd_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;

    logic [WIDTH-1:0] sum, diff, alu_c;
    logic             alu_ovf;
    logic [SH_W-1:0]  sh_amt;
    logic             is_signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sh_amt       = bus.b[SH_W-1:0];
    assign sum          = bus.a + bus.b;
    assign diff         = bus.a - bus.b;
    assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_mag        = (is_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag        = (is_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_comb begin
        alu_c   = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:  alu_c = bus.a & bus.b;
            OP_OR:   alu_c = bus.a | bus.b;
            OP_XOR:  alu_c = bus.a ^ bus.b;
            OP_NOR:  alu_c = ~(bus.a | bus.b);
            OP_ADD: begin
                alu_c   = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c   = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  alu_c = bus.a << sh_amt;
            OP_SRL:  alu_c = bus.a >> sh_amt;
            OP_SRA:  alu_c = $signed(bus.a) >>> sh_amt;
            default: alu_c = '0;
        endcase
    end

    // Multiplier step: the product of magnitudes accumulates in 2*WIDTH bits.
    logic [2*WIDTH-1:0] mul_acc_next, mul_prod;
    assign mul_acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_prod     = neg_q_reg ? -mul_acc_next : mul_acc_next;

    // Restoring divider step; the partial remainder stays below the divisor,
    // so the subtraction result always fits in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic             div_by_zero;
    logic [WIDTH-1:0] div_sub, div_rem_next, div_quo_next, div_q_fin, div_r_fin;
    assign div_shift    = {rem_reg, quo_reg[WIDTH-1]};
    assign div_ge       = div_shift >= {1'b0, dvs_reg};
    assign div_sub      = div_shift[WIDTH-1:0] - dvs_reg;
    assign div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
    assign div_quo_next = {quo_reg[WIDTH-2:0], div_ge};
    assign div_by_zero  = (dvs_reg == '0);
    assign div_q_fin    = div_by_zero ? '1 : (neg_q_reg ? -div_quo_next : div_quo_next);
    assign div_r_fin    = div_by_zero ? dvd_reg : (neg_r_reg ? -div_rem_next : div_rem_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            dz_reg        <= 1'b0;
            c_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            acc_reg       <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            dvd_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
                                mplier_reg <= b_mag;
                                acc_reg    <= '0;
                                neg_q_reg  <= is_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                cnt_reg    <= CNT_LAST;
                                ready_reg  <= 1'b0;
                                state_reg  <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                rem_reg   <= '0;
                                quo_reg   <= a_mag;
                                dvs_reg   <= b_mag;
                                dvd_reg   <= bus.a;
                                neg_q_reg <= is_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r_reg <= is_signed_op && bus.a[WIDTH-1];
                                cnt_reg   <= CNT_LAST;
                                ready_reg <= 1'b0;
                                state_reg <= DIV;
                            end
                            default: begin
                                c_reg         <= alu_c;
                                ovf_reg       <= alu_ovf;
                                dz_reg        <= 1'b0;
                                out_valid_reg <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_reg    <= mul_acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (cnt_reg == '0) begin
                        hi_reg        <= mul_prod[2*WIDTH-1:WIDTH];
                        lo_reg        <= mul_prod[WIDTH-1:0];
                        c_reg         <= mul_prod[WIDTH-1:0];
                        ovf_reg       <= 1'b0;
                        dz_reg        <= 1'b0;
                        out_valid_reg <= 1'b1;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DIV: begin
                    rem_reg <= div_rem_next;
                    quo_reg <= div_quo_next;
                    if (cnt_reg == '0) begin
                        hi_reg        <= div_r_fin;
                        lo_reg        <= div_q_fin;
                        c_reg         <= div_q_fin;
                        ovf_reg       <= 1'b0;
                        dz_reg        <= div_by_zero;
                        out_valid_reg <= 1'b1;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.c         = c_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.dz        = dz_reg;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are queued at accept time
// from a behavioural model and compared when out_valid appears.
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3;
    localparam logic [3:0] OP_MULT = 4'd4, OP_MULTU = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8, OP_SLL = 4'd9, OP_SRL = 4'd10, OP_SRA = 4'd11;
    localparam logic [3:0] OP_NOR = 4'd12, OP_DIV = 4'd13, OP_DIVU = 4'd14, OP_NONE = 4'd15;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] c;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int edge_cnt = 0;
    int last_acc = 0;
    int ov_cnt = 0;
    exp_t e_push, e_mon;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
        exp_t e;
        longint sa, sb_, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.op = op; e.c = '0; e.hi = cur_hi; e.lo = cur_lo; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 0; e.acc = 0;
        case (op)
            OP_AND:  e.c = a & b;
            OP_OR:   e.c = a | b;
            OP_XOR:  e.c = a ^ b;
            OP_NOR:  e.c = ~(a | b);
            OP_ADD:  begin e.c = a + b; e.ovf = (a[W-1] == b[W-1]) && (e.c[W-1] != a[W-1]); end
            OP_SUB:  begin e.c = a - b; e.ovf = (a[W-1] != b[W-1]) && (e.c[W-1] != a[W-1]); end
            OP_SLT:  e.c = (sa < sb_) ? 32'd1 : 32'd0;
            OP_SLTU: e.c = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  e.c = a << b[4:0];
            OP_SRL:  e.c = a >> b[4:0];
            OP_SRA:  e.c = 32'(sa >>> b[4:0]);
            OP_MULT: begin p = sa * sb_; {e.hi, e.lo} = p; e.lat = W; e.c = e.lo; end
            OP_MULTU: begin u = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = u; e.lat = W; e.c = e.lo; end
            OP_DIV, OP_DIVU: begin
                e.lat = W;
                if (b == '0) begin
                    e.dz = 1'b1; e.lo = '1; e.hi = a;
                end else if (op == OP_DIV) begin
                    e.lo = 32'(sa / sb_); e.hi = 32'(sa % sb_);
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
                e.c = e.lo;
            end
            default: e.c = '0;
        endcase
        return e;
    endfunction

    // Record accepts and queue the expected response.
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            e_push = model(bus.op, bus.a, bus.b, m_hi, m_lo);
            e_push.acc = edge_cnt;
            if (e_push.lat != 0) begin
                m_hi = e_push.hi;
                m_lo = e_push.lo;
            end
            sb.push_back(e_push);
            last_acc = edge_cnt;
        end
        edge_cnt = edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            ov_cnt++;
            if (sb.size() == 0) begin
                check("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e_mon = sb.pop_front();
                $display("result op=%0d c=0x%08h hi=0x%08h lo=0x%08h ovf=%0b dz=%0b",
                         e_mon.op, bus.c, bus.hi, bus.lo, bus.ovf, bus.dz);
                check($sformatf("op%0d_c", e_mon.op), {32'd0, bus.c}, {32'd0, e_mon.c});
                check($sformatf("op%0d_hi", e_mon.op), {32'd0, bus.hi}, {32'd0, e_mon.hi});
                check($sformatf("op%0d_lo", e_mon.op), {32'd0, bus.lo}, {32'd0, e_mon.lo});
                check($sformatf("op%0d_ovf", e_mon.op), {63'd0, bus.ovf}, {63'd0, e_mon.ovf});
                check($sformatf("op%0d_dz", e_mon.op), {63'd0, bus.dz}, {63'd0, e_mon.dz});
                check($sformatf("op%0d_latency", e_mon.op), 64'(edge_cnt - 1 - e_mon.acc), 64'(e_mon.lat));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_c"}, {32'd0, bus.c}, 64'd0);
        check({tag, "_hi"}, {32'd0, bus.hi}, 64'd0);
        check({tag, "_lo"}, {32'd0, bus.lo}, 64'd0);
        check({tag, "_ovf"}, {63'd0, bus.ovf}, 64'd0);
        check({tag, "_dz"}, {63'd0, bus.dz}, 64'd0);
    endtask

    logic [3:0] single_ops [12] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT,
                                    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_NOR, OP_NONE};
    logic [3:0] md_ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    initial begin
        int mul_acc;
        int ov_before;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single-cycle ops, back to back.
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        send(OP_SUB, 32'd5, 32'd7);
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        send(OP_SRA, 32'h8000_0000, 32'd4);
        send(OP_SLL, 32'h0000_0003, 32'd33);
        send(OP_SRL, 32'hF000_0000, 32'd31);
        send(OP_SUB, 32'h8000_0000, 32'd1);
        send(OP_XOR, 32'hA5A5_5A5A, 32'hFFFF_0000);
        send(OP_NOR, 32'h0F0F_0000, 32'h0000_00F0);
        send(OP_NONE, 32'h1234_5678, 32'h9ABC_DEF0);
        idle(2);
        drain();

        // Multiply / divide.
        send(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
        send(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        send(OP_DIVU, 32'd100, 32'd7);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        send(OP_DIVU, 32'd9, 32'd0);
        send(OP_ADD, 32'd1, 32'd1);
        idle(1);
        drain();

        // A request held during a busy multiply is taken WIDTH+1 edges later.
        send(OP_MULT, 32'd12345, 32'hFFFF_0001);
        mul_acc = last_acc;
        send(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        check("held_accept_edge", 64'(last_acc - mul_acc), 64'(W + 1));
        idle(1);
        drain();

        // Random single-cycle ops.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            send(single_ops[$urandom_range(0, 11)], ra, rb);
        end
        idle(1);
        drain();

        // Random mul/div, including divide by zero.
        for (int i = 0; i < 10; i++) begin
            ra = (i == 3) ? 32'h8000_0000 : $urandom;
            rb = (i % 5 == 2) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            send(md_ops[$urandom_range(0, 3)], ra, rb);
        end
        idle(1);
        drain();

        // Reset in the middle of a multiply aborts it.
        send(OP_MULT, 32'd5, 32'd6);
        idle(0);
        repeat (9) @(posedge clk);
        #2;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov_before = ov_cnt;
        repeat (40) @(negedge clk);
        check("no_result_after_abort", 64'(ov_cnt - ov_before), 64'd0);
        send(OP_ADD, 32'd1, 32'd2);
        idle(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
